ps2_keymap: RTL and testbench

- Sits between the PS/2 receiver and the video-memory text writer.
- Consumes raw set-2 scan-code bytes, tracks the make/break/extended prefixes and the modifier state (shift, ctrl, caps lock), and translates make codes to ASCII.
- Presents each character to the text writer through a one-entry valid/ready output register.
- Also exports the caps-lock LED state, an emitted-character counter, and a sticky overflow flag.

---
 rtl/ps2_keymap.sv | 249 ++++++++++++++++++++++++
 tb/tb_ps2_keymap.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keymap.sv
// ps2_keymap: translates PS/2 set-2 scan-code bytes into ASCII characters.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   scan_code    byte from the PS/2 receiver
//   scan_valid   one-cycle strobe qualifying scan_code
//   ascii_out    translated character (held while waiting for the consumer)
//   ascii_valid  ascii_out holds an unconsumed character
//   ascii_ready  consumer accepts ascii_out when high together with ascii_valid
//   caps_led     current caps-lock state
//   key_count    characters loaded into the output register, wraps at 256
//   overflow     sticky, set when a character is dropped because the output is full
//
// State table (prefix tracker):
//   state   | meaning
//   IDLE    | no prefix pending; next byte is a make code or a prefix
//   BRK     | F0 seen; next byte is a break code
//   EXT     | E0 seen; next byte is an extended make or F0
//   EXT_BRK | E0 F0 seen; next byte is an extended break code
module ps2_keymap #(
  parameter bit CAPS_EN = 1'b1,
  parameter bit CTRL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       caps_led,
  output logic [7:0] key_count,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic code_make;
  logic code_break;
  logic code_ext;

  logic lshift, rshift, lctrl, rctrl, caps_held;
  logic shift, ctrl;

  logic [4:0] letter_idx;
  logic       digit_hit;
  logic [3:0] digit_val;
  logic       map_hit;
  logic [7:0] map_char;
  logic       new_char;

  assign shift = lshift | rshift;
  assign ctrl  = lctrl | rctrl;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (scan_code == 8'hF0)      state_nxt = BRK;
          else if (scan_code == 8'hE0) state_nxt = EXT;
          else                         state_nxt = IDLE;
        end
        BRK:     state_nxt = IDLE;
        EXT:     state_nxt = (scan_code == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: classify the current byte as a make or break code
  always_comb begin
    code_make  = 1'b0;
    code_break = 1'b0;
    code_ext   = 1'b0;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          case (scan_code)
            8'hF0, 8'hE0, 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
            default: code_make = 1'b1;
          endcase
        end
        BRK: code_break = 1'b1;
        EXT: begin
          if (scan_code != 8'hF0) begin
            code_make = 1'b1;
            code_ext  = 1'b1;
          end
        end
        EXT_BRK: begin
          code_break = 1'b1;
          code_ext   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Letter / digit key lookup
  always_comb begin
    letter_idx = 5'd0;
    digit_hit  = 1'b0;
    digit_val  = 4'd0;
    case (scan_code)
      8'h1C: letter_idx = 5'd1;
      8'h32: letter_idx = 5'd2;
      8'h21: letter_idx = 5'd3;
      8'h23: letter_idx = 5'd4;
      8'h24: letter_idx = 5'd5;
      8'h2B: letter_idx = 5'd6;
      8'h34: letter_idx = 5'd7;
      8'h33: letter_idx = 5'd8;
      8'h43: letter_idx = 5'd9;
      8'h3B: letter_idx = 5'd10;
      8'h42: letter_idx = 5'd11;
      8'h4B: letter_idx = 5'd12;
      8'h3A: letter_idx = 5'd13;
      8'h31: letter_idx = 5'd14;
      8'h44: letter_idx = 5'd15;
      8'h4D: letter_idx = 5'd16;
      8'h15: letter_idx = 5'd17;
      8'h2D: letter_idx = 5'd18;
      8'h1B: letter_idx = 5'd19;
      8'h2C: letter_idx = 5'd20;
      8'h3C: letter_idx = 5'd21;
      8'h2A: letter_idx = 5'd22;
      8'h1D: letter_idx = 5'd23;
      8'h22: letter_idx = 5'd24;
      8'h35: letter_idx = 5'd25;
      8'h1A: letter_idx = 5'd26;
      8'h45: begin digit_hit = 1'b1; digit_val = 4'd0; end
      8'h16: begin digit_hit = 1'b1; digit_val = 4'd1; end
      8'h1E: begin digit_hit = 1'b1; digit_val = 4'd2; end
      8'h26: begin digit_hit = 1'b1; digit_val = 4'd3; end
      8'h25: begin digit_hit = 1'b1; digit_val = 4'd4; end
      8'h2E: begin digit_hit = 1'b1; digit_val = 4'd5; end
      8'h36: begin digit_hit = 1'b1; digit_val = 4'd6; end
      8'h3D: begin digit_hit = 1'b1; digit_val = 4'd7; end
      8'h3E: begin digit_hit = 1'b1; digit_val = 4'd8; end
      8'h46: begin digit_hit = 1'b1; digit_val = 4'd9; end
      default: ;
    endcase
  end

  // Character mapping with the modifier state as it stands before this byte
  always_comb begin
    map_hit  = 1'b0;
    map_char = 8'h00;
    if (letter_idx != 5'd0) begin
      map_hit = 1'b1;
      if (CTRL_EN && ctrl)         map_char = {3'b000, letter_idx};
      else if (shift ^ caps_led)   map_char = 8'h40 + {3'b000, letter_idx};
      else                         map_char = 8'h60 + {3'b000, letter_idx};
    end else if (digit_hit) begin
      map_hit = 1'b1;
      if (shift) begin
        case (digit_val)
          4'd0:    map_char = 8'h29; // )
          4'd1:    map_char = 8'h21; // !
          4'd2:    map_char = 8'h40; // @
          4'd3:    map_char = 8'h23; // #
          4'd4:    map_char = 8'h24; // $
          4'd5:    map_char = 8'h25; // %
          4'd6:    map_char = 8'h5E; // ^
          4'd7:    map_char = 8'h26; // &
          4'd8:    map_char = 8'h2A; // *
          default: map_char = 8'h28; // (
        endcase
      end else begin
        map_char = 8'h30 + {4'b0000, digit_val};
      end
    end else begin
      case (scan_code)
        8'h29: begin map_hit = 1'b1; map_char = 8'h20; end
        8'h5A: begin map_hit = 1'b1; map_char = 8'h0A; end
        8'h66: begin map_hit = 1'b1; map_char = 8'h08; end
        8'h0D: begin map_hit = 1'b1; map_char = 8'h09; end
        8'h4E: begin map_hit = 1'b1; map_char = shift ? 8'h5F : 8'h2D; end
        8'h55: begin map_hit = 1'b1; map_char = shift ? 8'h2B : 8'h3D; end
        default: ;
      endcase
    end
  end

  assign new_char = code_make & ~code_ext & map_hit;

  // Modifier and caps-lock tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      caps_held <= 1'b0;
      caps_led  <= 1'b0;
    end else if (code_make || code_break) begin
      if (!code_ext) begin
        if (scan_code == 8'h12) lshift <= code_make;
        if (scan_code == 8'h59) rshift <= code_make;
        if (scan_code == 8'h14) lctrl  <= code_make;
        if (scan_code == 8'h58) begin
          caps_held <= code_make;
          // typematic repeats arrive with caps_held set and must not retoggle
          if (CAPS_EN && code_make && !caps_held) caps_led <= ~caps_led;
        end
      end else if (scan_code == 8'h14) begin
        rctrl <= code_make;
      end
    end
  end

  // One-entry output register; a slot freed by a handshake can be refilled the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ascii_out   <= 8'h00;
      ascii_valid <= 1'b0;
      key_count   <= 8'h00;
      overflow    <= 1'b0;
    end else if (new_char) begin
      if (!ascii_valid || ascii_ready) begin
        ascii_out   <= map_char;
        ascii_valid <= 1'b1;
        key_count   <= key_count + 8'd1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (ascii_valid && ascii_ready) begin
      ascii_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_keymap.sv
// Testbench for ps2_keymap: scoreboard of expected characters, popped on each handshake.
module tb_ps2_keymap;

  logic       clk;
  logic       reset;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       caps_led;
  logic [7:0] key_count;
  logic       overflow;

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  logic [7:0] exp_count;

  ps2_keymap #(.CAPS_EN(1'b1), .CTRL_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .ascii_out  (ascii_out),
    .ascii_valid(ascii_valid),
    .ascii_ready(ascii_ready),
    .caps_led   (caps_led),
    .key_count  (key_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every handshake must match the oldest expected character.
  always @(negedge clk) begin
    if (reset && ascii_valid && ascii_ready) begin
      logic [7:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_char got %h required none", ascii_out);
      end else begin
        e = exp_q.pop_front();
        if (ascii_out !== e) begin
          errors++;
          $display("FAIL char got %h required %h", ascii_out, e);
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(c);
    exp_count = exp_count + 8'd1;
    send(b);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 600) begin
      tick(1);
      budget++;
    end
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending %0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    reset       = 1'b0;
    scan_valid  = 1'b0;
    scan_code   = 8'h00;
    ascii_ready = 1'b1;
    exp_q.delete();
    exp_count = 8'h00;
    #3;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if ({ascii_out, ascii_valid, caps_led, key_count, overflow} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state got %h/%b/%b/%h/%b required 00/0/0/00/0",
               ascii_out, ascii_valid, caps_led, key_count, overflow);
    end
    apply_reset();
  endtask

  task automatic test_make_break();
    checks++;
    if (ascii_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid got %b required 0", ascii_valid);
    end
    send_exp(8'h1C, 8'h61);
    checks++;
    if (ascii_valid !== 1'b1 || ascii_out !== 8'h61 || key_count !== 8'd1) begin
      errors++;
      $display("FAIL latency got %b/%h/%0d required 1/61/1", ascii_valid, ascii_out, key_count);
    end
    send(8'hF0); send(8'h1C);
    tick(3);
    checks++;
    if (ascii_valid !== 1'b0 || key_count !== exp_count) begin
      errors++;
      $display("FAIL break_silent got %b/%0d required 0/%0d", ascii_valid, key_count, exp_count);
    end
    drain();
  endtask

  task automatic test_shift();
    send(8'h12);
    send_exp(8'h1C, 8'h41);
    send(8'hF0); send(8'h12);
    send_exp(8'h1C, 8'h61);
    send(8'h59);
    send_exp(8'h16, 8'h21);
    send_exp(8'h4E, 8'h5F);
    send_exp(8'h55, 8'h2B);
    send(8'hF0); send(8'h59);
    send_exp(8'h45, 8'h30);
    send_exp(8'h3E, 8'h38);
    send_exp(8'h29, 8'h20);
    send_exp(8'h5A, 8'h0A);
    send_exp(8'h66, 8'h08);
    send_exp(8'h0D, 8'h09);
    send_exp(8'h55, 8'h3D);
    send(8'h76);
    send(8'hAA);
    drain();
  endtask

  task automatic test_caps();
    send(8'h58);
    checks++;
    if (caps_led !== 1'b1) begin
      errors++;
      $display("FAIL caps_on got %b required 1", caps_led);
    end
    send(8'h58);
    checks++;
    if (caps_led !== 1'b1) begin
      errors++;
      $display("FAIL caps_repeat got %b required 1", caps_led);
    end
    send(8'hF0); send(8'h58);
    send_exp(8'h1C, 8'h41);
    send(8'h12);
    send_exp(8'h1C, 8'h61);
    send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58);
    checks++;
    if (caps_led !== 1'b0) begin
      errors++;
      $display("FAIL caps_off got %b required 0", caps_led);
    end
    drain();
  endtask

  task automatic test_ctrl_ext();
    send(8'h14);
    send_exp(8'h21, 8'h03);
    send(8'hF0); send(8'h14);
    send(8'hE0); send(8'h14);
    send_exp(8'h1A, 8'h1A);
    send(8'hE0); send(8'hF0); send(8'h14);
    send_exp(8'h21, 8'h63);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h12);
    send_exp(8'h1C, 8'h61);
    send(8'hE0); send(8'hF0); send(8'h12);
    drain();
    checks++;
    if (key_count !== exp_count) begin
      errors++;
      $display("FAIL ext_count got %0d required %0d", key_count, exp_count);
    end
  endtask

  task automatic test_same_cycle_handshake();
    ascii_ready = 1'b0;
    send_exp(8'h16, 8'h31);
    tick(1);
    ascii_ready = 1'b1;
    send_exp(8'h1E, 8'h32);
    checks++;
    if (ascii_valid !== 1'b1 || ascii_out !== 8'h32 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL handshake_load got %b/%h/%b required 1/32/0", ascii_valid, ascii_out, overflow);
    end
    drain();
  endtask

  task automatic test_overflow();
    ascii_ready = 1'b0;
    send_exp(8'h16, 8'h31);
    send(8'h1E);
    tick(2);
    checks++;
    if (ascii_out !== 8'h31 || ascii_valid !== 1'b1 || overflow !== 1'b1 || key_count !== exp_count) begin
      errors++;
      $display("FAIL overflow got %h/%b/%b/%0d required 31/1/1/%0d",
               ascii_out, ascii_valid, overflow, key_count, exp_count);
    end
    ascii_ready = 1'b1;
    drain();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got %b required 1", overflow);
    end
  endtask

  task automatic test_reset_midseq();
    send(8'h58); send(8'hF0); send(8'h58);
    send(8'hE0); send(8'hF0);
    reset = 1'b0;
    exp_q.delete();
    exp_count = 8'h00;
    #2;
    checks++;
    if (caps_led !== 1'b0 || key_count !== 8'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midseq_reset got %b/%0d/%b required 0/0/0", caps_led, key_count, overflow);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    send_exp(8'h1C, 8'h61);
    drain();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 256; i++) send_exp(8'h1C, 8'h61);
    drain();
    checks++;
    if (key_count !== 8'd0 || ascii_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap got %0d/%b/%b required 0/0/0", key_count, ascii_valid, overflow);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_count   = 8'h00;
    reset       = 1'b0;
    scan_code   = 8'h00;
    scan_valid  = 1'b0;
    ascii_ready = 1'b1;
    test_reset();
    test_make_break();
    test_shift();
    test_caps();
    test_ctrl_ext();
    test_same_cycle_handshake();
    test_overflow();
    test_reset_midseq();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
